tilt_mover: RTL and testbench

Converts signed accelerometer tilt samples into one-hot single-cycle `movement` pulses for the ball controller. Each axis runs a rate accumulator, so a steeper tilt produces more frequent steps. Tilt inside a deadzone produces no steps. Pulses are spaced by a guaranteed gap that exceeds the ball's worst-case wall-check time, so the ball is always idle when a pulse arrives and no pulse is lost or doubled.

---
 rtl/tilt_mover.sv | 188 ++++++++++++++++++
 tb/tb_tilt_mover.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tilt_mover.sv
// Tilt-to-movement converter: per-axis rate accumulators feed a one-hot pulse
// issuer that guarantees a fixed idle gap after every pulse.
module tilt_mover #(
  parameter int CLK_FREQUENCY_HZ  = 100000000,
  parameter int TICK_HZ           = 1000,
  parameter int SIMULATE          = 0,
  parameter int SIMULATE_TICK_CNT = 5,
  parameter int ACCEL_WIDTH       = 12,
  parameter int DEADZONE          = 64,
  parameter int MAX_RATE          = 512,
  parameter int ACC_WIDTH         = 16,
  parameter int STEP_THRESHOLD    = 1024,
  parameter int MIN_GAP_CYCLES    = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [ACCEL_WIDTH-1:0] accel_x,
  input  logic [ACCEL_WIDTH-1:0] accel_y,
  input  logic                   accel_valid,
  output logic [3:0]             movement,
  output logic                   busy
);
  localparam int TICK_N = (SIMULATE != 0) ? SIMULATE_TICK_CNT : CLK_FREQUENCY_HZ / TICK_HZ;
  localparam int TW     = (TICK_N > 1) ? $clog2(TICK_N) : 1;
  localparam int GW     = (MIN_GAP_CYCLES > 1) ? $clog2(MIN_GAP_CYCLES) : 1;
  localparam int SW     = ACC_WIDTH + 1;

  localparam logic [TW-1:0] LP_TICK_LAST = TW'(TICK_N - 1);
  localparam logic [GW-1:0] LP_GAP_LAST  = GW'(MIN_GAP_CYCLES - 1);
  localparam logic [SW-1:0] LP_DZ        = SW'(DEADZONE);
  localparam logic [SW-1:0] LP_MAX       = SW'(MAX_RATE);
  localparam logic [SW-1:0] LP_THR       = SW'(STEP_THRESHOLD);

  localparam logic [3:0] MV_UP    = 4'b0001;
  localparam logic [3:0] MV_DOWN  = 4'b0010;
  localparam logic [3:0] MV_LEFT  = 4'b0100;
  localparam logic [3:0] MV_RIGHT = 4'b1000;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PULSE = 2'd1, S_GAP = 2'd2} state_t;

  // accel_valid is a one-cycle strobe with no back-pressure: the sample on
  // accel_x/accel_y is captured on any clock where it is high.
  logic [ACCEL_WIDTH-1:0] r_ax, r_ay;
  logic [TW-1:0]          r_tick_cnt;
  logic [ACC_WIDTH-1:0]   r_acc_x, r_acc_y;
  logic                   r_pend_x, r_pend_y;
  logic                   r_dir_x, r_dir_y;
  state_t                 r_state;
  logic [GW-1:0]          r_gap_cnt;
  logic [3:0]             r_movement;
  logic                   r_busy;
  logic                   r_issue_y;
  logic                   r_last_y;

  logic [SW-1:0] w_ex_x, w_ex_y, w_sum_x, w_sum_y, w_sub_x, w_sub_y;
  logic          w_tick, w_cross_x, w_cross_y, w_clr_x, w_clr_y;
  logic          w_start, w_pick_y, w_tie, w_launch;
  logic [3:0]    w_dir;

  function automatic logic [SW-1:0] f_excess(input logic [ACCEL_WIDTH-1:0] a);
    logic [ACCEL_WIDTH-1:0] mag;
    logic [SW-1:0]          mag_w;
    logic [SW-1:0]          ex;
    mag   = a[ACCEL_WIDTH-1] ? (-a) : a;
    mag_w = SW'(mag);
    ex    = (mag_w > LP_DZ) ? (mag_w - LP_DZ) : '0;
    return (ex > LP_MAX) ? LP_MAX : ex;
  endfunction

  assign w_tick    = (r_tick_cnt == LP_TICK_LAST);
  assign w_ex_x    = f_excess(r_ax);
  assign w_ex_y    = f_excess(r_ay);
  assign w_sum_x   = {1'b0, r_acc_x} + w_ex_x;
  assign w_sum_y   = {1'b0, r_acc_y} + w_ex_y;
  assign w_cross_x = (w_sum_x >= LP_THR);
  assign w_cross_y = (w_sum_y >= LP_THR);
  assign w_sub_x   = w_sum_x - LP_THR;
  assign w_sub_y   = w_sum_y - LP_THR;
  assign w_clr_x   = (r_state == S_PULSE) && !r_issue_y;
  assign w_clr_y   = (r_state == S_PULSE) && r_issue_y;

  // The last GAP cycle may launch directly so pulses can be exactly one gap apart.
  assign w_start  = enable && (r_pend_x || r_pend_y);
  assign w_tie    = r_pend_x && r_pend_y;
  assign w_pick_y = r_pend_y && (!r_pend_x || !r_last_y);
  assign w_dir    = w_pick_y ? (r_dir_y ? MV_DOWN : MV_UP) : (r_dir_x ? MV_LEFT : MV_RIGHT);
  assign w_launch = w_start && ((r_state == S_IDLE) ||
                                ((r_state == S_GAP) && (r_gap_cnt == LP_GAP_LAST)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ax       <= '0;
      r_ay       <= '0;
      r_tick_cnt <= '0;
      r_acc_x    <= '0;
      r_acc_y    <= '0;
      r_pend_x   <= 1'b0;
      r_pend_y   <= 1'b0;
      r_dir_x    <= 1'b0;
      r_dir_y    <= 1'b0;
    end else begin
      if (accel_valid) begin
        r_ax <= accel_x;
        r_ay <= accel_y;
      end
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      if (!enable) begin
        r_acc_x  <= '0;
        r_acc_y  <= '0;
        r_pend_x <= 1'b0;
        r_pend_y <= 1'b0;
      end else begin
        // Later assignments override the pulse clear, so a same-cycle set wins.
        if (w_clr_x) r_pend_x <= 1'b0;
        if (w_clr_y) r_pend_y <= 1'b0;
        if (w_tick && (w_ex_x != '0)) begin
          if (r_ax[ACCEL_WIDTH-1] != r_dir_x) begin
            r_acc_x  <= w_ex_x[ACC_WIDTH-1:0];
            r_pend_x <= 1'b0;
            r_dir_x  <= r_ax[ACCEL_WIDTH-1];
          end else if (w_cross_x) begin
            r_acc_x  <= w_sub_x[ACC_WIDTH-1:0];
            r_pend_x <= 1'b1;
          end else begin
            r_acc_x  <= w_sum_x[ACC_WIDTH-1:0];
          end
        end
        if (w_tick && (w_ex_y != '0)) begin
          if (r_ay[ACCEL_WIDTH-1] != r_dir_y) begin
            r_acc_y  <= w_ex_y[ACC_WIDTH-1:0];
            r_pend_y <= 1'b0;
            r_dir_y  <= r_ay[ACCEL_WIDTH-1];
          end else if (w_cross_y) begin
            r_acc_y  <= w_sub_y[ACC_WIDTH-1:0];
            r_pend_y <= 1'b1;
          end else begin
            r_acc_y  <= w_sum_y[ACC_WIDTH-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_gap_cnt  <= '0;
      r_movement <= '0;
      r_busy     <= 1'b0;
      r_issue_y  <= 1'b0;
      r_last_y   <= 1'b1;
    end else begin
      r_movement <= '0;
      if (w_launch) begin
        r_state    <= S_PULSE;
        r_busy     <= 1'b1;
        r_movement <= w_dir;
        r_issue_y  <= w_pick_y;
        if (w_tie) r_last_y <= ~r_last_y;
      end else begin
        case (r_state)
          S_IDLE: r_busy <= 1'b0;
          S_PULSE: begin
            r_state   <= S_GAP;
            r_gap_cnt <= '0;
          end
          S_GAP: begin
            if (r_gap_cnt == LP_GAP_LAST) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_gap_cnt <= r_gap_cnt + GW'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign movement = r_movement;
  assign busy     = r_busy;

endmodule

// File: tb/tb_tilt_mover.sv
// Bench for tilt_mover: directed scenarios plus random tilt traffic, checked
// cycle by cycle against an integer reference model of the stepping rules.
module tb_tilt_mover;
  localparam int N    = 5;
  localparam int M    = 8;
  localparam int DZ   = 64;
  localparam int MAXR = 512;
  localparam int THR  = 1024;
  localparam logic [3:0] UP = 4'b0001, DOWN = 4'b0010, LEFT = 4'b0100, RIGHT = 4'b1000;

  logic        clk, reset, enable, accel_valid, busy;
  logic [11:0] accel_x, accel_y;
  logic [3:0]  movement;

  int n_tests = 0;
  int n_fail  = 0;

  tilt_mover #(
    .SIMULATE(1), .SIMULATE_TICK_CNT(N), .MIN_GAP_CYCLES(M)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .accel_x(accel_x), .accel_y(accel_y), .accel_valid(accel_valid),
    .movement(movement), .busy(busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: plain integer arithmetic, advanced once per rising edge
  int         cyc = 0;
  int         m_tcnt, m_left, m_axis, m_last;
  int         m_s[2], m_acc[2];
  bit         m_pend[2], m_neg[2];
  logic [3:0] m_mov;
  int         tick_log[$];
  logic [3:0] exp_q[$];

  function automatic int excess(input int a);
    int mag, e;
    mag = (a < 0) ? -a : a;
    e   = (mag > DZ) ? mag - DZ : 0;
    return (e > MAXR) ? MAXR : e;
  endfunction

  always @(posedge clk) begin
    bit         issue, tick, neg;
    int         ax, e;
    logic [3:0] dir;
    bit         clr[2];
    cyc++;
    if (reset) begin
      m_tcnt = 0; m_left = 0; m_axis = 0; m_last = 1; m_mov = 4'b0;
      for (int i = 0; i < 2; i++) begin
        m_s[i] = 0; m_acc[i] = 0; m_pend[i] = 0; m_neg[i] = 0;
      end
      tick_log.delete();
      exp_q.delete();
    end else begin
      issue = 0; dir = 4'b0; ax = 0;
      clr[0] = (m_left == M + 1) && (m_axis == 0);
      clr[1] = (m_left == M + 1) && (m_axis == 1);
      if (enable && m_left <= 1 && (m_pend[0] || m_pend[1])) begin
        issue = 1;
        if (m_pend[0] && m_pend[1]) begin
          ax = (m_last == 1) ? 0 : 1;
          m_last = ax;
        end else begin
          ax = m_pend[0] ? 0 : 1;
        end
        m_axis = ax;
        dir = (ax == 0) ? (m_neg[0] ? LEFT : RIGHT) : (m_neg[1] ? DOWN : UP);
      end
      tick = (m_tcnt == N - 1);
      for (int i = 0; i < 2; i++) begin
        if (!enable) begin
          m_acc[i] = 0; m_pend[i] = 0;
        end else begin
          if (clr[i]) m_pend[i] = 0;
          e = excess(m_s[i]);
          if (tick && e != 0) begin
            neg = (m_s[i] < 0);
            if (neg != m_neg[i]) begin
              m_neg[i] = neg; m_acc[i] = e; m_pend[i] = 0;
            end else begin
              m_acc[i] += e;
              if (m_acc[i] >= THR) begin
                m_acc[i] -= THR; m_pend[i] = 1;
              end
            end
          end
        end
      end
      if (tick) tick_log.push_back(cyc);
      if (accel_valid) begin
        m_s[0] = $signed(accel_x);
        m_s[1] = $signed(accel_y);
      end
      m_tcnt = tick ? 0 : m_tcnt + 1;
      if (issue) begin
        m_left = M + 1; m_mov = dir; exp_q.push_back(dir);
      end else begin
        m_left = (m_left > 0) ? m_left - 1 : 0; m_mov = 4'b0;
      end
    end
  end

  // scoreboard: per-cycle outputs, pulse sequence and pulse-shape rules
  int         p_cyc[$];
  logic [3:0] p_dir[$];
  logic [3:0] prev_mov = 4'b0;
  int         last_pulse = -1;

  always @(negedge clk) begin
    check("movement", movement, m_mov);
    check("busy", busy, (m_left > 0));
    if (reset) last_pulse = -1;
    if (movement != 4'b0) begin
      check("onehot", $onehot(movement), 1);
      check("no_back_to_back", (prev_mov != 4'b0), 0);
      if (last_pulse >= 0) check("min_spacing", ((cyc - last_pulse) >= M + 1), 1);
      if (exp_q.size() == 0) check("unexpected_pulse", movement, 4'b0);
      else check("pulse_seq", movement, exp_q.pop_front());
      last_pulse = cyc;
      p_cyc.push_back(cyc);
      p_dir.push_back(movement);
    end
    prev_mov = movement;
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    step(n);
    reset = 1'b0;
  endtask

  task automatic strobe(input int x, input int y);
    accel_x = 12'(x);
    accel_y = 12'(y);
    accel_valid = 1'b1;
    step(1);
    accel_valid = 1'b0;
  endtask

  task automatic clear_log();
    p_cyc.delete();
    p_dir.delete();
  endtask

  task automatic wait_pulses(input int k, input int budget, input string tag);
    int n;
    n = 0;
    while (p_cyc.size() < k && n < budget) begin
      step(1);
      n++;
    end
    check(tag, (p_cyc.size() >= k), 1);
  endtask

  function automatic int nth_tick_after(input int s, input int n);
    int c;
    c = 0;
    foreach (tick_log[i]) begin
      if (tick_log[i] > s) begin
        c++;
        if (c == n) return tick_log[i];
      end
    end
    return -1;
  endfunction

  int s0, s1, n;

  initial begin
    reset = 1'b1; enable = 1'b0; accel_valid = 1'b0; accel_x = '0; accel_y = '0;
    step(3);
    reset = 1'b0;
    check("reset_mov", movement, 4'b0);
    check("reset_busy", busy, 0);

    // 1: reset during GAP
    enable = 1'b1;
    strobe(600, 0);
    wait_pulses(1, 60, "s1_first_pulse");
    step(3);
    reset = 1'b1;
    step(1);
    check("s1_rst_mov", movement, 4'b0);
    check("s1_rst_busy", busy, 0);
    step(2);
    reset = 1'b0;
    clear_log();
    step(2 * N + 2);
    check("s1_quiet", p_cyc.size(), 0);

    // 2: deadzone edge, then full negative clamp
    do_reset(2);
    enable = 1'b1;
    strobe(64, 0);
    clear_log();
    step(50 * N);
    check("s2_deadzone", p_cyc.size(), 0);
    strobe(-2048, 0);
    wait_pulses(3, 120, "s2_pulses");
    if (p_cyc.size() >= 3) begin
      check("s2_dir", p_dir[0], LEFT);
      check("s2_gap1", p_cyc[1] - p_cyc[0], 10);
      check("s2_gap2", p_cyc[2] - p_cyc[1], 10);
    end

    // 3: excess 512, first pulse right after the second tick
    do_reset(2);
    enable = 1'b1;
    strobe(576, 0);
    s0 = cyc;
    clear_log();
    wait_pulses(2, 80, "s3_pulses");
    if (p_cyc.size() >= 2) begin
      check("s3_dir0", p_dir[0], RIGHT);
      check("s3_dir1", p_dir[1], RIGHT);
      check("s3_first", p_cyc[0], nth_tick_after(s0, 2) + 1);
      check("s3_period", p_cyc[1] - p_cyc[0], 10);
    end

    // 4: both axes pending, alternation starting with X
    do_reset(2);
    enable = 1'b1;
    strobe(600, -600);
    clear_log();
    wait_pulses(4, 200, "s4_pulses");
    if (p_cyc.size() >= 4) begin
      check("s4_dir0", p_dir[0], RIGHT);
      check("s4_dir1", p_dir[1], DOWN);
      check("s4_dir2", p_dir[2], RIGHT);
      check("s4_dir3", p_dir[3], DOWN);
    end

    // 5: sign flip reloads the accumulator
    do_reset(2);
    enable = 1'b1;
    strobe(320, 0);
    s0 = cyc;
    clear_log();
    n = 0;
    while (nth_tick_after(s0, 2) < 0 && n < 50) begin
      step(1);
      n++;
    end
    check("s5_no_early_pulse", p_cyc.size(), 0);
    strobe(-320, 0);
    s1 = cyc;
    wait_pulses(1, 80, "s5_pulse");
    if (p_cyc.size() >= 1) begin
      check("s5_dir", p_dir[0], LEFT);
      check("s5_time", p_cyc[0], nth_tick_after(s1, 4) + 1);
    end

    // 6: enable dropped during GAP with the other axis pending
    do_reset(2);
    enable = 1'b1;
    strobe(600, 600);
    clear_log();
    wait_pulses(1, 60, "s6_first");
    step(2);
    enable = 1'b0;
    clear_log();
    step(30);
    check("s6_no_pulse", p_cyc.size(), 0);
    check("s6_idle", busy, 0);
    enable = 1'b1;
    s1 = cyc;
    wait_pulses(1, 80, "s6_resume");
    if (p_cyc.size() >= 1) begin
      check("s6_resume_dir", p_dir[0], UP);
      check("s6_resume_time", p_cyc[0], nth_tick_after(s1, 2) + 1);
    end

    // random traffic against the model
    do_reset(2);
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: strobe($urandom_range(0, 4095), $urandom_range(0, 4095));
          1: strobe(int'($urandom_range(0, 8)) + 60, -(int'($urandom_range(0, 8)) + 60));
          2: strobe(-(int'($urandom_range(300, 2048))), int'($urandom_range(300, 2047)));
          default: strobe(0, int'($urandom_range(0, 1200)) - 600);
        endcase
      end
      if ($urandom_range(0, 149) == 0) do_reset(1);
      step($urandom_range(1, 12));
    end
    enable = 1'b0;
    step(M + 4);
    check("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
